// File: rtl/serial_link_pkg.sv
// Shared definitions for the LSB-first serial link (transmitter and receiver).
package serial_link_pkg;

  localparam int unsigned SERIAL_WORD_LENGTH = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } rx_state_t;

endpackage : serial_link_pkg

// File: rtl/sipo_lsb_receiver_if.sv
// Receiver-side bundle of the serial link: frame strobes, serial data and the
// parallel-word valid/ack handshake.
//   master : drives start/shift/serialInput/ack, observes the receiver outputs
//   slave  : the receiver itself
interface sipo_lsb_receiver_if
  import serial_link_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = SERIAL_WORD_LENGTH
);

  logic                   start;
  logic                   shift;
  logic                   serialInput;
  logic                   ack;
  logic [WORD_LENGTH-1:0] parallelOutput;
  logic                   valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output start, shift, serialInput, ack,
    input  parallelOutput, valid, busy, overrun
  );

  modport slave (
    input  start, shift, serialInput, ack,
    output parallelOutput, valid, busy, overrun
  );

endinterface : sipo_lsb_receiver_if

// File: rtl/sipo_lsb_receiver_bit_counter.sv
// Bit position counter for one frame.
//   clk, rst     : clock, async active-low reset
//   i_clear      : synchronous clear (wins over enable)
//   i_enable     : count up by one
//   o_count      : current bit index
//   o_terminal_c : combinational, high when o_count == WORD_LENGTH-1
module bit_counter
  import serial_link_pkg::*;
#(
  parameter  int unsigned WORD_LENGTH = SERIAL_WORD_LENGTH,
  localparam int unsigned CNT_W       = $clog2(WORD_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_terminal_c
);

  logic [CNT_W-1:0] r_count;

  // The owner clears on the terminal bit, so the counter never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count      = r_count;
  assign o_terminal_c = (r_count == CNT_W'(WORD_LENGTH - 1));

endmodule : bit_counter

// File: rtl/sipo_lsb_receiver.sv
// LSB-first serial-in/parallel-out receiver with valid/ack output register
// and sticky overrun flag.
//   clk, rst : clock, async active-low reset
//   bus      : start/shift/serialInput/ack in; parallelOutput/valid/busy/overrun out
module sipo_lsb_receiver
  import serial_link_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = SERIAL_WORD_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_lsb_receiver_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WORD_LENGTH);

  rx_state_t              r_state;
  rx_state_t              w_next_state;
  logic [WORD_LENGTH-1:0] r_sr;
  logic [WORD_LENGTH-1:0] r_pout;
  logic                   r_valid;
  logic                   r_overrun;

  logic                   w_cnt_clear;
  logic                   w_cnt_en;
  logic                   w_take_bit;
  logic                   w_complete;
  logic                   w_terminal;
  logic [CNT_W-1:0]       w_count;
  logic [WORD_LENGTH-1:0] w_shifted;

  bit_counter #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_cnt_clear),
    .i_enable     (w_cnt_en),
    .o_count      (w_count),
    .o_terminal_c (w_terminal)
  );

  assign w_shifted = {bus.serialInput, r_sr[WORD_LENGTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and counter control; start overrides a coincident shift
  always_comb begin
    w_next_state = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    w_take_bit   = 1'b0;
    w_complete   = 1'b0;
    if (bus.start) begin
      w_next_state = RECEIVE;
      w_cnt_clear  = 1'b1;
    end else if (r_state == RECEIVE && bus.shift) begin
      w_take_bit = 1'b1;
      if (w_terminal) begin
        w_complete   = 1'b1;
        w_cnt_clear  = 1'b1;
        w_next_state = IDLE;
      end else begin
        w_cnt_en = 1'b1;
      end
    end
  end

  // Shift register, output word and handshake flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr      <= '0;
      r_pout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.start) begin
        r_sr <= '0;
      end else if (w_take_bit) begin
        r_sr <= w_shifted;
      end

      if (w_complete) begin
        r_pout <= w_shifted;
      end

      if (w_complete) begin
        r_valid <= 1'b1;
      end else if (bus.ack && r_valid) begin
        r_valid <= 1'b0;
      end

      // An ack in the completing cycle consumes the old word, so no overrun
      if (w_complete && r_valid && !bus.ack) begin
        r_overrun <= 1'b1;
      end else if (bus.ack && r_valid) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.parallelOutput = r_pout;
  assign bus.valid          = r_valid;
  assign bus.busy           = (r_state == RECEIVE);
  assign bus.overrun        = r_overrun;

  logic w_unused;
  assign w_unused = ^w_count;

endmodule : sipo_lsb_receiver

// File: tb/tb_sipo_lsb_receiver.sv
// Directed bench for sipo_lsb_receiver, including loopback from a behavioural
// LSB-first PISO transmitter.
module tb_sipo_lsb_receiver;
  import serial_link_pkg::*;

  localparam int unsigned WL = SERIAL_WORD_LENGTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          tb_start = 1'b0;
  logic          tb_shift = 1'b0;
  logic          tb_ser   = 1'b0;
  logic          tb_ack   = 1'b0;
  logic          loop_en  = 1'b0;
  logic          load     = 1'b0;
  logic          pshift   = 1'b0;
  logic [WL-1:0] pin      = '0;
  logic [WL-1:0] piso     = '0;

  int n_checks = 0;
  int n_errors = 0;

  sipo_lsb_receiver_if #(.WORD_LENGTH(WL)) bus ();

  assign bus.start       = loop_en ? load    : tb_start;
  assign bus.shift       = loop_en ? pshift  : tb_shift;
  assign bus.serialInput = loop_en ? piso[0] : tb_ser;
  assign bus.ack         = tb_ack;

  sipo_lsb_receiver #(.WORD_LENGTH(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Transmitter model: LSB on serialOutput, shifts right on each shift strobe
  always @(posedge clk) begin
    if (load) piso <= pin;
    else if (pshift) piso <= piso >> 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [WL-1:0] pout,
                            input logic v, input logic b, input logic o);
    check({tag, ".pout"},    32'(bus.parallelOutput), 32'(pout));
    check({tag, ".valid"},   32'(bus.valid),          32'(v));
    check({tag, ".busy"},    32'(bus.busy),           32'(b));
    check({tag, ".overrun"}, 32'(bus.overrun),        32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    tb_shift = 1'b1;
    tb_ser   = b;
    tick();
    tb_shift = 1'b0;
    tb_ser   = 1'b0;
  endtask

  task automatic pulse_start();
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
  endtask

  task automatic pulse_ack();
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
  endtask

  task automatic send_word(input logic [WL-1:0] w, input int nbits);
    pulse_start();
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
  endtask

  initial begin
    logic [WL-1:0] w;
    logic          seen_valid;
    logic [WL-1:0] words [20];

    // Reset, then reset mid-frame
    tick();
    tick();
    check_outs("rst", '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    w = 8'hFF;
    send_word(w, 3);
    check("midframe.busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_outs("rst_mid", '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < WL; i++) send_bit(1'b1);
    check_outs("no_start", '0, 1'b0, 1'b0, 1'b0);

    // Single word 8'hA5
    w = 8'hA5;
    send_word(w, WL - 1);
    check("A5.pre.valid", 32'(bus.valid), 32'd0);
    check("A5.pre.busy",  32'(bus.busy),  32'd1);
    send_bit(w[WL-1]);
    check_outs("A5", 8'hA5, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    check_outs("A5_ack", 8'hA5, 1'b0, 1'b0, 1'b0);
    pulse_ack();
    check_outs("ack_idle", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Overrun
    w = 8'h3C;
    send_word(w, WL);
    check_outs("3C", 8'h3C, 1'b1, 1'b0, 1'b0);
    w = 8'hC3;
    send_word(w, WL);
    check_outs("C3_ovr", 8'hC3, 1'b1, 1'b0, 1'b1);
    pulse_ack();
    check_outs("C3_ack", 8'hC3, 1'b0, 1'b0, 1'b0);

    // Completion in the same cycle as ack
    w = 8'h11;
    send_word(w, WL);
    check_outs("11", 8'h11, 1'b1, 1'b0, 1'b0);
    w = 8'h22;
    send_word(w, WL - 1);
    tb_ack = 1'b1;
    send_bit(w[WL-1]);
    tb_ack = 1'b0;
    check_outs("22_simul", 8'h22, 1'b1, 1'b0, 1'b0);
    pulse_ack();

    // Restart mid-frame with shift coincident with start
    seen_valid = 1'b0;
    w = 8'hFF;
    send_word(w, 4);
    tb_start = 1'b1;
    tb_shift = 1'b1;
    tb_ser   = 1'b1;
    tick();
    tb_start = 1'b0;
    tb_shift = 1'b0;
    tb_ser   = 1'b0;
    check("restart.busy", 32'(bus.busy), 32'd1);
    w = 8'h5A;
    for (int i = 0; i < WL; i++) begin
      send_bit(w[i]);
      if (i < WL - 1 && bus.valid) seen_valid = 1'b1;
    end
    check("restart.early_valid", 32'(seen_valid), 32'd0);
    check_outs("5A", 8'h5A, 1'b1, 1'b0, 1'b0);
    pulse_ack();

    // Loopback from the PISO model with random shift gaps
    words[0] = 8'h96;
    words[1] = 8'h00;
    words[2] = 8'hFF;
    for (int i = 3; i < 20; i++) words[i] = 8'($urandom);
    loop_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pin  = words[k];
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int b = 0; b < WL; b++) begin
        repeat ($urandom_range(0, 3)) tick();
        pshift = 1'b1;
        tick();
        pshift = 1'b0;
      end
      check($sformatf("loop%0d.pout", k), 32'(bus.parallelOutput), 32'(words[k]));
      check($sformatf("loop%0d.valid", k), 32'(bus.valid), 32'd1);
      check($sformatf("loop%0d.overrun", k), 32'(bus.overrun), 32'd0);
      pulse_ack();
    end
    loop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sipo_lsb_receiver
